// File: rtl/fifo_byte_tx.sv
// Pops one FIFO word at a time and sends it as four bytes on a valid/ready stream.
// First byte 3 cycles after fifo_empty falls. A low byte_ready holds the current byte.
module fifo_byte_tx #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_rd_ack,
  input  logic        fifo_rd_err,
  output logic        fifo_rd_en,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic [7:0]  word_count,
  output logic        rd_err_flag,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold;
  logic [1:0]  idx;
  logic [1:0]  byte_sel;
  logic        byte_fire;

  assign byte_fire = (state == SEND) && byte_ready;
  // The inverted index walks the word from the top byte down.
  assign byte_sel  = MSB_FIRST ? ~idx : idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    state_nxt = fifo_rd_ack ? SEND : IDLE;
      SEND:    if (byte_ready && (idx == 2'd3)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state == REQ);
    byte_valid = (state == SEND);
    busy       = (state != IDLE);
    byte_last  = (state == SEND) && (idx == 2'd3);
    byte_out   = 8'd0;
    if (state == SEND) begin
      byte_out = hold[{byte_sel, 3'b000} +: 8];
    end
  end

  // dout is only meaningful in WAIT; the FIFO zeroes it on every other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold        <= 32'd0;
      idx         <= 2'd0;
      word_count  <= 8'd0;
      rd_err_flag <= 1'b0;
    end else begin
      if (state == WAIT) begin
        if (fifo_rd_ack) begin
          hold <= fifo_dout;
          idx  <= 2'd0;
        end
        if (fifo_rd_err) begin
          rd_err_flag <= 1'b1;
        end
      end
      if (byte_fire) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          word_count <= word_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/fifo_byte_tx.md
# fifo_byte_tx

Downstream drain stage for the 32-bit FIFO. It pops one word at a time through the FIFO's read port, captures the registered `dout`/`rd_ack` pair, and serializes the word into four bytes on a valid/ready byte stream. It also keeps a word counter and a sticky read-error flag for status.

## Interface
- `MSB_FIRST`, default 0: byte order. 0 sends `[7:0]` first; 1 sends `[31:24]` first.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dout`  in  32  FIFO `dout`, registered inside the FIFO and zero when no read occurred.
- `fifo_rd_ack`  in  1  FIFO read acknowledge.
- `fifo_rd_err`  in  1  FIFO read error (read while empty).
- `fifo_rd_en`  out  1  FIFO read request.
- `byte_out`  out  8  current byte.
- `byte_valid`  out  1  `byte_out` is valid.
- `byte_ready`  in  1  sink accepts the byte this cycle.
- `byte_last`  out  1  current byte is the 4th byte of its word.
- `word_count`  out  8  number of words fully sent, modulo 256.
- `rd_err_flag`  out  1  sticky; set on any `fifo_rd_err` seen in WAIT.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states and outputs:
  - IDLE: no outputs asserted.
  - REQ: `fifo_rd_en`=1.
  - WAIT: waiting on the FIFO response.
  - SEND: `byte_valid`=1.
- `fifo_rd_en` and `byte_valid` are decoded from the state register only (Moore, no input paths).
- Transitions:
  - IDLE→REQ when `fifo_empty`=0. Otherwise stay in IDLE.
  - REQ→WAIT unconditionally. `fifo_rd_en` is therefore high for exactly one cycle per word.
  - WAIT, `fifo_rd_ack`=1: load `fifo_dout` into the 32-bit hold register, clear `idx`, go to SEND.
  - WAIT, `fifo_rd_err`=1 or no ack: go to IDLE, set `rd_err_flag` if `fifo_rd_err`=1, send nothing.
  - SEND: on `byte_valid`&&`byte_ready`, `idx`←`idx`+1. If `idx`==3 when accepted, `word_count`←`word_count`+1 and go to IDLE.
- Byte select:
  - `MSB_FIRST`=0: byte = hold[8·idx+7 : 8·idx].
  - `MSB_FIRST`=1: byte = hold[31−8·idx : 24−8·idx].
- `byte_last` = SEND && `idx`==3.
- `byte_out` is 0 outside SEND. While stalled (valid && !ready), `byte_out`, `byte_last` and `idx` stay unchanged.
- `idx` is 2 bits. `word_count` wraps from 255 to 0 with no flag.
- `rd_err_flag` is cleared only by `reset`.
- Only one word is ever in flight. There is no read-ahead, so the FIFO is never over-read by this block.

## Timing
- Reset values: state IDLE, hold 0, `idx` 0, `word_count` 0, `rd_err_flag` 0. All outputs are 0.
- `reset` has priority over every other input in the same cycle.
- Reset mid-word abandons the word. Bytes not yet sent are lost, and the FIFO is not rewound.
- Latency from `fifo_empty` falling, observed in cycle t:
  - t+1: `fifo_rd_en`=1.
  - t+2: WAIT, sampling `fifo_dout`/`fifo_rd_ack`.
  - t+3: first `byte_valid`.
- With `byte_ready` held high, bytes go out in t+3..t+6, IDLE is reached at t+7, and the next REQ occurs at t+8 if the FIFO is still non-empty. Throughput is 1 word per 7 cycles.
- `fifo_dout` is captured only in WAIT. It is ignored in every other state, since the FIFO zeroes it on non-read cycles.
- `fifo_empty` changing during REQ/WAIT/SEND has no effect. A late empty is caught by `fifo_rd_err` in WAIT.
- `byte_ready` is sampled only in SEND. Ready asserted with no valid is ignored.

## Test plan
- Reset, then FIFO holds 0x44332211, `byte_ready`=1, `MSB_FIRST`=0 → `fifo_rd_en` pulses 1 cycle, bytes 11,22,33,44 appear in consecutive cycles starting 3 cycles after empty falls, `byte_last` on 44, `word_count`=1.
- Same word with `MSB_FIRST`=1 → bytes 44,33,22,11 in that order.
- Stall: `byte_ready` low for 5 cycles on the 2nd byte → `byte_out`=22 held stable and valid throughout the stall, no duplicate or skipped byte, and `word_count` increments only after byte 4 is accepted.
- Back-to-back: FIFO pre-loaded with 8 words, ready=1 → 32 bytes in order, `fifo_rd_en` high exactly 8 times at 7-cycle spacing, `word_count`=8, FIFO ends empty.
- Error: force `fifo_rd_ack`=0 and `fifo_rd_err`=1 in WAIT → returns to IDLE, no `byte_valid`, `rd_err_flag`=1 and it stays set after the next good word.
- Reset mid-SEND after byte 2, plus a wrap check of 256 words → all outputs 0 the cycle after reset with no further bytes, and `word_count` reads 0 after 256 words.
